// File: rtl/fir_pkg.sv
// fir_pkg: shared FIR constants and controller state type
package fir_pkg;
    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int TAPS   = 64;
    localparam int ADDR_W = $clog2(TAPS);
    localparam int ACC_W  = DATA_W + COEF_W + ADDR_W;
    typedef enum logic [1:0] {IDLE, SHIFT, MAC, DONE} fir_state_t;
endpackage

// File: rtl/fir_mac_ctrl_if.sv
// fir_mac_ctrl_if: sample input, shift register, coefficient ROM and result stream signals
interface fir_mac_ctrl_if import fir_pkg::*; ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] sample_in;
    logic [DATA_W-1:0] sr_din;
    logic              sr_shift;
    logic [ADDR_W-1:0] sr_addr;
    logic [DATA_W-1:0] sr_dout;
    logic [ADDR_W-1:0] coef_addr;
    logic [COEF_W-1:0] coef;
    logic [ACC_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    modport master (
        input  in_valid, sample_in, sr_dout, coef, out_ready,
        output in_ready, sr_din, sr_shift, sr_addr, coef_addr, out_data, out_valid
    );
    modport slave (
        output in_valid, sample_in, sr_dout, coef, out_ready,
        input  in_ready, sr_din, sr_shift, sr_addr, coef_addr, out_data, out_valid
    );
endinterface

// File: rtl/fir_mac_unit.sv
// fir_mac_unit: signed multiply with full-precision accumulator, sync clear and enable
module fir_mac_unit import fir_pkg::*; (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [COEF_W-1:0] i_b,
    output logic signed [ACC_W-1:0]  o_acc
);
    logic signed [DATA_W+COEF_W-1:0] w_prod;
    logic signed [ACC_W-1:0]         w_prod_ext;
    logic signed [ACC_W-1:0]         r_acc;
    assign w_prod     = i_a * i_b;
    assign w_prod_ext = {{ADDR_W{w_prod[DATA_W+COEF_W-1]}}, w_prod};
    assign o_acc      = r_acc;
    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_acc <= '0;
        else if (i_en)
            r_acc <= r_acc + w_prod_ext;
    end
endmodule

// File: rtl/fir_mac_ctrl.sv
// fir_mac_ctrl: accepts a sample, shifts it into the tap register, then
// sweeps all taps through one MAC and presents the result on a handshake.
module fir_mac_ctrl import fir_pkg::*; (
    input  logic           clk,
    input  logic           rst,
    fir_mac_ctrl_if.master bus
);
    fir_state_t              r_state;
    logic [ADDR_W-1:0]       r_cnt;
    logic [DATA_W-1:0]       r_din;
    logic signed [ACC_W-1:0] w_acc;
    logic                    w_last;
    assign w_last        = r_cnt == ADDR_W'(TAPS - 1);
    assign bus.in_ready  = r_state == IDLE;
    assign bus.sr_shift  = r_state == SHIFT;
    assign bus.sr_din    = r_din;
    assign bus.sr_addr   = r_cnt;
    assign bus.coef_addr = r_cnt;
    assign bus.out_valid = r_state == DONE;
    assign bus.out_data  = w_acc;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_din   <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_din   <= bus.sample_in;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    r_cnt   <= '0;
                    r_state <= MAC;
                end
                MAC: begin
                    r_cnt   <= w_last ? '0 : r_cnt + ADDR_W'(1);
                    r_state <= w_last ? DONE : MAC;
                end
                DONE: if (bus.out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
    // the accumulator is cleared while the new sample is being shifted in
    fir_mac_unit u_mac (
        .clk   (clk),
        .rst   (rst),
        .i_clr (r_state == SHIFT),
        .i_en  (r_state == MAC),
        .i_a   ($signed(bus.sr_dout)),
        .i_b   ($signed(bus.coef)),
        .o_acc (w_acc)
    );
endmodule

// File: tb/tb_fir_mac_ctrl.sv
// tb_fir_mac_ctrl: vector tables, corner sequences and random samples checked
// against a sum-of-products model over the accepted-sample history.
module tb_fir_mac_ctrl;
    import fir_pkg::*;

    typedef struct {
        longint sample;
        longint expect_out;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_mac_ctrl_if bus();
    fir_mac_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    logic signed [DATA_W-1:0] sr_mem   [TAPS];
    logic signed [COEF_W-1:0] coef_rom [TAPS];
    int     shifts = 0;
    int     total  = 0;
    int     bad    = 0;
    longint hist[$];
    longint last_out;
    vec_t   tv[70];

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) sr_mem[k] <= '0;
        end else if (bus.sr_shift) begin
            for (int k = TAPS - 1; k > 0; k--) sr_mem[k] <= sr_mem[k-1];
            sr_mem[0] <= bus.sr_din;
            shifts <= shifts + 1;
        end
    end
    assign bus.sr_dout = sr_mem[bus.sr_addr];
    assign bus.coef    = coef_rom[bus.coef_addr];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint model();
        longint s = 0;
        for (int k = 0; k < TAPS; k++)
            if (k < hist.size()) s += hist[k] * longint'(coef_rom[k]);
        return s;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hist.delete();
    endtask

    task automatic send(input longint s, input int hold, input longint s2);
        int lat, w, sh0;
        bit sweep_ok;
        longint exp, held;
        logic [ADDR_W-1:0] addrs [TAPS];
        w = 0;
        while (!bus.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            chk("ready_wait", 0, 1);
            return;
        end
        bus.in_valid  = 1'b1;
        bus.sample_in = DATA_W'(s);
        bus.out_ready = (hold == 0);
        sh0 = shifts;
        @(negedge clk);
        bus.in_valid = 1'b0;
        hist.push_front(s);
        if (hist.size() > TAPS) void'(hist.pop_back());
        chk("shift_pulse", longint'(bus.sr_shift), 1);
        chk("sr_din", longint'($signed(bus.sr_din)), s);
        chk("busy_ready", longint'(bus.in_ready), 0);
        lat = 1;
        sweep_ok = 1'b1;
        while (!bus.out_valid && lat < 200) begin
            if (lat >= 2 && lat < TAPS + 2) begin
                addrs[lat-2] = bus.sr_addr;
                if (bus.coef_addr !== bus.sr_addr) sweep_ok = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, TAPS + 2);
        for (int k = 0; k < TAPS; k++)
            if (addrs[k] !== ADDR_W'(k)) sweep_ok = 1'b0;
        chk("addr_sweep", longint'(sweep_ok), 1);
        chk("shift_count", shifts - sh0, 1);
        exp = model();
        last_out = longint'($signed(bus.out_data));
        chk("out_data", last_out, exp);
        held = last_out;
        for (int i = 0; i < hold; i++) begin
            if (i == 2) begin
                bus.in_valid  = 1'b1;
                bus.sample_in = DATA_W'(s2);
            end
            @(negedge clk);
            chk("bp_valid", longint'(bus.out_valid), 1);
            chk("bp_data", longint'($signed(bus.out_data)), held);
            chk("bp_ready", longint'(bus.in_ready), 0);
            chk("bp_shift", shifts - sh0, 1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("valid_drop", longint'(bus.out_valid), 0);
        chk("idle_ready", longint'(bus.in_ready), 1);
        if (hold > 0) chk("no_early_shift", shifts - sh0, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic signed [DATA_W-1:0] r;
        int seen;
        bus.in_valid  = 1'b0;
        bus.sample_in = '0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < TAPS; k++) coef_rom[k] = 16'sd1;

        rst = 1'b1;
        bus.in_valid  = 1'b1;
        bus.sample_in = 16'd123;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", longint'(bus.in_ready), 1);
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_sr_shift", longint'(bus.sr_shift), 0);
        chk("rst_out_data", longint'($signed(bus.out_data)), 0);
        chk("rst_sr_din", longint'(bus.sr_din), 0);
        chk("rst_sr_addr", longint'(bus.sr_addr), 0);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        hist.delete();
        @(negedge clk);
        chk("rst_no_accept", shifts, 0);

        send(5, 0, 0);
        chk("single_5", last_out, 5);

        for (int k = 0; k < TAPS; k++) coef_rom[k] = COEF_W'(k + 1);
        do_reset();
        for (int n = 0; n < 70; n++) begin
            tv[n].sample     = (n == 0) ? 1 : 0;
            tv[n].expect_out = (n < TAPS) ? n + 1 : 0;
        end
        for (int n = 0; n < 70; n++) begin
            send(tv[n].sample, 0, 0);
            chk("impulse", last_out, tv[n].expect_out);
        end

        for (int k = 0; k < TAPS; k++) coef_rom[k] = -16'sd32768;
        do_reset();
        for (int n = 0; n < TAPS; n++) begin
            tv[n].sample     = -32768;
            tv[n].expect_out = longint'(n + 1) << 30;
        end
        for (int n = 0; n < TAPS; n++) begin
            send(tv[n].sample, 0, 0);
            chk("extreme", last_out, tv[n].expect_out);
        end
        chk("extreme_2e36", last_out, 64'sd68719476736);

        for (int k = 0; k < TAPS; k++) begin
            r = DATA_W'($urandom);
            coef_rom[k] = r;
        end
        do_reset();
        send(-1234, 10, 777);
        send(777, 0, 0);

        bus.in_valid  = 1'b1;
        bus.sample_in = 16'd50;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (21) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hist.delete();
        chk("midrst_ready", longint'(bus.in_ready), 1);
        chk("midrst_valid", longint'(bus.out_valid), 0);
        chk("midrst_acc", longint'($signed(bus.out_data)), 0);
        chk("midrst_addr", longint'(bus.sr_addr), 0);
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("midrst_no_output", seen, 0);
        send(-300, 0, 0);
        chk("midrst_next", last_out, -300 * longint'(coef_rom[0]));

        for (int n = 0; n < 20; n++) begin
            r = DATA_W'($urandom);
            send(longint'(r), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
